seq_detect_prog: RTL
====================

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning maximum pattern length in bits (2..16).
REQ-002 SHALL have parameter LEN_W, default 4, meaning width of cfg_len; it must satisfy 2^LEN_W > MAX_LEN.
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of the match counter.
REQ-004 SHALL have port clk, input, 1 bit, meaning the clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning reset: synchronous, active-high.
REQ-006 SHALL have port cfg_we, input, 1 bit, meaning load cfg_pattern/cfg_len/cfg_overlap this cycle.
REQ-007 SHALL have port cfg_pattern, input, MAX_LEN bits, meaning the target pattern; bit [len-1] is the first-received bit and bit 0 the last.
REQ-008 SHALL have port cfg_len, input, LEN_W bits, meaning the pattern length.
REQ-009 SHALL have port cfg_overlap, input, 1 bit, meaning 1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have port in_valid, input, 1 bit, meaning in_bit is valid this cycle.
REQ-011 SHALL have port in_bit, input, 1 bit, meaning serial data bit.
REQ-012 SHALL have port match, output, 1 bit, meaning Mealy match, combinational, in the same cycle as the completing bit.
REQ-013 SHALL have port match_q, output, 1 bit, meaning match registered one cycle later.
REQ-014 SHALL have port match_count, output, CNT_W bits, meaning saturating count of matches since reset or reconfiguration.
REQ-015 SHALL have port enabled, output, 1 bit, meaning a valid configuration is active.

Function
REQ-016 SHALL hold configuration registers pat_r, len_r and ovl_r, loaded only when cfg_we=1.
REQ-017 SHALL clamp len_r to MAX_LEN when cfg_len > MAX_LEN.
REQ-018 SHALL treat len_r of 0 or 1 as disabled: enabled=0, match never asserts.
REQ-019 SHALL run a two-state FSM: DISABLED and HUNT.
- DISABLED -> HUNT on cfg_we with a valid length (2..MAX_LEN after clamping).
- HUNT -> DISABLED on cfg_we with length 0/1.
- HUNT -> HUNT on cfg_we with a valid length, which reloads the configuration.
- enabled=1 exactly when the state is HUNT.
REQ-020 SHALL keep a history shift register hist[MAX_LEN-2:0]; on in_valid=1 it shifts in_bit into bit 0.
REQ-021 SHALL keep a fill counter: it counts accepted bits since the last clear and saturates at MAX_LEN.
REQ-022 SHALL assert match = in_valid & enabled & ~cfg_we & (fill >= len_r-1) & ({hist[len_r-2:0], in_bit} == pat_r[len_r-1:0]).
REQ-023 SHALL, in overlap mode, leave hist and fill unchanged by a match; shifting continues normally.
REQ-024 SHALL, in non-overlap mode, set fill to 0 on a match cycle, so the next match needs len_r fresh bits.
REQ-025 SHALL hold all state on in_valid=0; match=0 and bubbles do not break a sequence.
REQ-026 SHALL load match_q <= match each cycle.
REQ-027 SHALL increment match_count by 1 per match, holding at 2^CNT_W-1 when saturated (no wrap).
REQ-028 SHALL give cfg_we priority over simultaneous in_valid: the bit is dropped, match=0, and hist, fill and match_count clear to 0.
REQ-029 SHALL update match_q and match_count on the same edge for a given match.

Reset
REQ-030 SHALL, with reset=1 at a rising edge, set: state=DISABLED, pat_r=0, len_r=0, ovl_r=1, hist=0, fill=0, match_count=0, match_q=0, enabled=0.
REQ-031 SHALL give reset priority over cfg_we and in_valid, and while reset=1 hold match=0.
REQ-032 SHALL, after reset mid-stream, discard partial history; detection restarts only after reconfiguration.

Verification
REQ-033 Overlap case: cfg pattern=101, len=3, overlap=1; stream 1,0,1,0,1 -> match on bits 3 and 5; match_count=2; match_q follows one cycle later.
REQ-034 Non-overlap case: same stream with overlap=0 -> match on bit 3 only; match_count=1; stream 1,0,1,1,0,1 -> matches on bits 3 and 6.
REQ-035 Bubbles: pattern 1101, len=4, bits 1,1,0,1 with in_valid low 2 cycles between each -> exactly one match, on the final bit.
REQ-036 Simultaneous events: cfg_we=1 together with a completing in_bit -> match=0, counter=0, history cleared; cfg_len=0 -> enabled=0, no matches on any stream.
REQ-037 Saturation and clamp: CNT_W=2, pattern 11, overlap=1, eight 1s -> count saturates at 3; cfg_len=15 with MAX_LEN=8 -> behaves as len 8.
REQ-038 Mid-stream reset: reset after bits 1,0 of 101 -> enabled=0, count=0; reconfigure, then bit 1 alone produces no match.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlapping and non-overlapping modes.
// Latency: match is combinational in the completing bit's cycle; match_q and match_count follow on the next edge.
// Backpressure: none. A cycle with in_valid low is a bubble that holds all state. cfg_we takes priority over the data bit.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_count,
  output logic               enabled
);

  typedef enum logic {
    ST_DISABLED = 1'b0,
    ST_HUNT     = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);

  state_t             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               match_r_q;

  logic [LEN_W-1:0]   len_clamped;
  logic               cfg_len_ok;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic               window_eq;
  logic [LEN_W:0]     fill_p1;
  logic               fill_ok;
  logic               accept;

  logic [MAX_LEN-2:0] hist_d;
  logic [LEN_W-1:0]   fill_d;
  logic [CNT_W-1:0]   cnt_d;

  // Lengths above the pattern register width behave as the full width; 0/1 disable detection.
  assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign cfg_len_ok  = (len_clamped >= LEN_MIN);

  // The newest len bits of the stream, with the arriving bit as the LSB, line up with pat_q[len-1:0].
  assign window = {hist_q, in_bit};

  // Select only the low len_q bits of the window and the pattern for comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign window_eq = ((window & len_mask) == (pat_q & len_mask));

  // fill + 1 >= len avoids the underflow of len - 1; enabled already guarantees len >= 2.
  assign fill_p1 = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
  assign fill_ok = (fill_p1 >= {1'b0, len_q});

  // Configuration writes swallow a data bit in the same cycle.
  assign accept = in_valid & ~cfg_we;

  assign match = ~reset & accept & (state_q == ST_HUNT) & fill_ok & window_eq;

  // Next-state datapath: shift history, advance or restart the fill count, and bump the saturating counter.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (cfg_we) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (in_valid) begin
      hist_d = window[MAX_LEN-2:0];
      if (match && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q < LEN_MAX) begin
        fill_d = fill_q + LEN_W'(1);
      end
      if (match && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Control FSM, configuration registers, and all registered state. Reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_DISABLED;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      match_r_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      match_r_q <= match;
      if (cfg_we) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamped;
        ovl_q <= cfg_overlap;
      end
      case (state_q)
        ST_DISABLED: if (cfg_we && cfg_len_ok) state_q <= ST_HUNT;
        ST_HUNT:     if (cfg_we && !cfg_len_ok) state_q <= ST_DISABLED;
        default:     state_q <= ST_DISABLED;
      endcase
    end
  end

  assign match_q     = match_r_q;
  assign match_count = cnt_q;
  assign enabled     = (state_q == ST_HUNT);

endmodule
